// File: rtl/bnn_pkg.sv
// bnn_pkg: shared loader state encoding and image-size constants for the BNN datapath.
package bnn_pkg;

    typedef enum logic [1:0] {LD_IDLE, LD_FILL, LD_FULL} loader_state_t;

    localparam int MNIST_PIXELS = 784;
    localparam int MAX_LANES = 8;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/bnn_lane_writer.sv
// bnn_lane_writer: per-lane pixel index and write-enable decode from the fill base, masking lanes past the image end.
module bnn_lane_writer
    import bnn_pkg::*;
#(
    parameter int N_PIXELS = MNIST_PIXELS,
    parameter int LANES = 2,
    parameter int CNT_W = $clog2(N_PIXELS + 1),
    parameter int IDX_W = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
    input  logic [CNT_W-1:0]            base,
    output logic [LANES-1:0]            lane_we,
    output logic [LANES-1:0][IDX_W-1:0] lane_idx,
    output logic [CNT_W-1:0]            step
);
    localparam logic [CNT_W:0] N_EXT = (CNT_W + 1)'(N_PIXELS);

    logic [CNT_W:0] remaining;

    // One extra bit keeps base+j from wrapping when the image size sits near a power of two.
    always_comb begin
        remaining = N_EXT - {1'b0, base};
        step = (remaining < (CNT_W + 1)'(LANES)) ? remaining[CNT_W-1:0] : CNT_W'(LANES);
        for (int j = 0; j < LANES; j++) begin
            lane_idx[j] = IDX_W'({1'b0, base} + (CNT_W + 1)'(j));
            lane_we[j] = (CNT_W + 1)'(j) < remaining;
        end
    end

endmodule

// File: rtl/bnn_pixel_loader.sv
// bnn_pixel_loader: multi-lane binarised image fill with progress, completion and overrun flags.
// Define BNN_LOADER_POPCOUNT_EN to add a running count of stored 1-bits.
module bnn_pixel_loader
    import bnn_pkg::*;
#(
    parameter int N_PIXELS = MNIST_PIXELS,
    parameter int LANES = 2,
    localparam int CNT_W = $clog2(N_PIXELS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_en,
    input  logic                frame_start,
    input  logic                in_valid,
    input  logic [LANES-1:0]    in_data,
    output logic [N_PIXELS-1:0] pixels,
    output logic [CNT_W-1:0]    pix_count,
    output logic                load_done,
    output logic                busy,
    output logic                overflow
`ifdef BNN_LOADER_POPCOUNT_EN
    ,
    output logic [CNT_W-1:0]    popcount
`endif
);
    localparam int IDX_W = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;

    loader_state_t state, state_next;
    logic [CNT_W-1:0] base, step, count_next;
    logic [LANES-1:0] lane_we;
    logic [LANES-1:0][IDX_W-1:0] lane_idx;
    logic offered, accept, overflow_next;
    logic [N_PIXELS-1:0] pixels_next;

    // frame_start rebases the fill to pixel 0 so a same-cycle beat lands as beat 0.
    assign offered = in_valid & load_en;
    assign accept = offered & (frame_start | (state != LD_FULL));
    assign base = frame_start ? '0 : pix_count;

    bnn_lane_writer #(
        .N_PIXELS(N_PIXELS),
        .LANES(LANES),
        .CNT_W(CNT_W),
        .IDX_W(IDX_W)
    ) u_lane_writer (
        .base(base),
        .lane_we(lane_we),
        .lane_idx(lane_idx),
        .step(step)
    );

    always_comb begin
        pixels_next = frame_start ? '0 : pixels;
        for (int j = 0; j < LANES; j++)
            if (accept && lane_we[j]) pixels_next[lane_idx[j]] = in_data[j];
        count_next = accept ? base + step : base;
        overflow_next = (offered & ~accept) | (overflow & ~frame_start);
        state_next = frame_start ? LD_IDLE : state;
        if (accept) state_next = (count_next == CNT_W'(N_PIXELS)) ? LD_FULL : LD_FILL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LD_IDLE;
            pixels <= '0;
            pix_count <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            pixels <= pixels_next;
            pix_count <= count_next;
            overflow <= overflow_next;
        end
    end

    assign load_done = state == LD_FULL;
    assign busy = state == LD_FILL;

`ifdef BNN_LOADER_POPCOUNT_EN
    logic [CNT_W-1:0] ones, pop_next;

    always_comb begin
        ones = '0;
        for (int j = 0; j < LANES; j++) ones = ones + CNT_W'(lane_we[j] & in_data[j]);
        pop_next = (frame_start ? '0 : popcount) + (accept ? ones : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) popcount <= '0;
        else popcount <= pop_next;
    end
`endif

endmodule

// File: tb/tb_bnn_pixel_loader.sv
// tb_bnn_pixel_loader: directed fills of a 2-lane and a 3-lane loader checked every cycle against an image-level model.
module tb_bnn_pixel_loader;
    localparam int N = 784;
    localparam int CW = $clog2(N + 1);

    logic clk = 1'b0;
    logic reset, load_en, frame_start, v2, v3;
    logic [1:0] d2;
    logic [2:0] d3;
    logic [N-1:0] pix2, pix3;
    logic [CW-1:0] cnt2, cnt3;
    logic done2, done3, busy2, busy3, ovf2, ovf3;
`ifdef BNN_LOADER_POPCOUNT_EN
    logic [CW-1:0] pop2, pop3;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    logic [N-1:0] m_pix [2];
    int m_cnt [2];
    int m_pop [2];
    bit m_full [2];
    bit m_ovf [2];

    always #5 clk = ~clk;

    bnn_pixel_loader #(.N_PIXELS(N), .LANES(2)) dut2 (
        .clk(clk), .reset(reset), .load_en(load_en), .frame_start(frame_start),
        .in_valid(v2), .in_data(d2), .pixels(pix2), .pix_count(cnt2),
        .load_done(done2), .busy(busy2), .overflow(ovf2)
`ifdef BNN_LOADER_POPCOUNT_EN
        , .popcount(pop2)
`endif
    );

    bnn_pixel_loader #(.N_PIXELS(N), .LANES(3)) dut3 (
        .clk(clk), .reset(reset), .load_en(load_en), .frame_start(frame_start),
        .in_valid(v3), .in_data(d3), .pixels(pix3), .pix_count(cnt3),
        .load_done(done3), .busy(busy3), .overflow(ovf3)
`ifdef BNN_LOADER_POPCOUNT_EN
        , .popcount(pop3)
`endif
    );

    // Image-level model: a beat fills the next free pixels, a beat while full only raises overflow.
    task automatic m_step(input int k, input int lanes, input bit v, input logic [7:0] d);
        if (reset) begin
            m_pix[k] = '0; m_cnt[k] = 0; m_pop[k] = 0; m_full[k] = 0; m_ovf[k] = 0;
        end else begin
            if (frame_start) begin
                m_pix[k] = '0; m_cnt[k] = 0; m_pop[k] = 0; m_full[k] = 0; m_ovf[k] = 0;
            end
            if (v && load_en) begin
                if (m_full[k]) m_ovf[k] = 1;
                else begin
                    for (int j = 0; j < lanes; j++)
                        if (m_cnt[k] + j < N) begin
                            m_pix[k][m_cnt[k] + j] = d[j];
                            m_pop[k] += int'(d[j]);
                        end
                    m_cnt[k] = (m_cnt[k] + lanes > N) ? N : m_cnt[k] + lanes;
                    m_full[k] = m_cnt[k] == N;
                end
            end
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_pix(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_pix("pixels2", pix2, m_pix[0]);
            lit("count2", 32'(cnt2), m_cnt[0]);
            lit("done2", 32'(done2), 32'(m_full[0]));
            lit("busy2", 32'(busy2), 32'(!m_full[0] && m_cnt[0] > 0));
            lit("ovf2", 32'(ovf2), 32'(m_ovf[0]));
            cmp_pix("pixels3", pix3, m_pix[1]);
            lit("count3", 32'(cnt3), m_cnt[1]);
            lit("done3", 32'(done3), 32'(m_full[1]));
            lit("busy3", 32'(busy3), 32'(!m_full[1] && m_cnt[1] > 0));
            lit("ovf3", 32'(ovf3), 32'(m_ovf[1]));
`ifdef BNN_LOADER_POPCOUNT_EN
            lit("pop2", 32'(pop2), m_pop[0]);
            lit("pop3", 32'(pop3), m_pop[1]);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        m_step(0, 2, v2, {6'b0, d2});
        m_step(1, 3, v3, {5'b0, d3});
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            d2 = 2'($urandom);
            d3 = 3'($urandom);
            tick();
        end
    endtask

    initial begin
        reset = 1; load_en = 0; frame_start = 0; v2 = 0; v3 = 0; d2 = 0; d3 = 0;
        @(negedge clk);
        tick();
        tick();
        chk_en = 1;
        lit("rst_count2", 32'(cnt2), 0);
        lit("rst_pixels2", 32'(pix2 == '0), 1);
        lit("rst_flags2", {29'b0, done2, busy2, ovf2}, 0);
        reset = 0;
        tick();

        load_en = 1; v2 = 1; d2 = 2'b01; d3 = 3'b111;
        for (int i = 0; i < 392; i++) begin
            v3 = i < 262;
            tick();
            if (i == 390) lit("t1_done_before_last", 32'(done2), 0);
        end
        lit("t1_count2", 32'(cnt2), 784);
        lit("t1_done2", 32'(done2), 1);
        lit("t1_even_odd", 32'(pix2 == {392{2'b01}}), 1);
        lit("t1_pix0", 32'(pix2[0]), 1);
        lit("t1_pix783", 32'(pix2[783]), 0);
        lit("t2_count3", 32'(cnt3), 784);
        lit("t2_all_ones", 32'(pix3 == {N{1'b1}}), 1);
        lit("t2_ovf3", 32'(ovf3), 0);
`ifdef BNN_LOADER_POPCOUNT_EN
        lit("t2_pop3", 32'(pop3), 784);
        lit("t1_pop2", 32'(pop2), 392);
`endif

        load_en = 0; v3 = 1;
        run(3);
        lit("full_le0_ovf2", 32'(ovf2), 0);
        load_en = 1;
        run(5);
        lit("t3_ovf2", 32'(ovf2), 1);
        lit("t3_unchanged", 32'(pix2 == {392{2'b01}}), 1);
        v2 = 0; v3 = 0; frame_start = 1;
        tick();
        frame_start = 0;
        lit("t3_fs_ovf", 32'(ovf2), 0);
        lit("t3_fs_count", 32'(cnt2), 0);
        lit("t3_fs_done", 32'(done2), 0);

        v2 = 1; v3 = 1;
        run(50);
        lit("t4_count100", 32'(cnt2), 100);
        load_en = 0;
        run(10);
        lit("t4_paused", 32'(cnt2), 100);
        lit("t4_busy", 32'(busy2), 1);
        load_en = 1;
        run(342);
        lit("t4_resume", 32'(cnt2), 784);

        v2 = 0; v3 = 0; frame_start = 1;
        tick();
        frame_start = 0; v2 = 1; v3 = 1;
        run(250);
        lit("t5_count500", 32'(cnt2), 500);
        frame_start = 1; d2 = 2'b11; d3 = 3'b101;
        tick();
        frame_start = 0;
        lit("t5_count2", 32'(cnt2), 2);
        lit("t5_pixels", 32'(pix2 == N'(2'b11)), 1);
        lit("t5_busy", 32'(busy2), 1);
        lit("t5_count3", 32'(cnt3), 3);

        run(149);
        lit("t6_count300", 32'(cnt2), 300);
        reset = 1; d2 = 2'b11;
        tick();
        reset = 0; v2 = 0; v3 = 0;
        lit("t6_count", 32'(cnt2), 0);
        lit("t6_pixels", 32'(pix2 == '0), 1);
        lit("t6_flags", {29'b0, done2, busy2, ovf2}, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
